// File: rtl/alu_cmd_ctrl_if.sv
// Byte-stream, register-file, ALU and transmit signals shared between the
// command sequencer (master) and its surroundings (slave).
interface alu_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0]   RX_P_DATA;
    logic                    RX_D_VLD;
    logic [2*DATA_WIDTH-1:0] ALU_OUT;
    logic                    ALU_OUT_VALID;
    logic                    TX_BUSY;
    logic [FUN_WIDTH-1:0]    ALU_FUN;
    logic                    ALU_EN;
    logic                    CLK_GATE_EN;
    logic                    RF_WrEn;
    logic [ADDR_WIDTH-1:0]   RF_Address;
    logic [DATA_WIDTH-1:0]   RF_WrData;
    logic [DATA_WIDTH-1:0]   TX_P_DATA;
    logic                    TX_D_VLD;
    logic                    ERR;

    modport master (
        input  RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VALID, TX_BUSY,
        output ALU_FUN, ALU_EN, CLK_GATE_EN, RF_WrEn, RF_Address, RF_WrData,
               TX_P_DATA, TX_D_VLD, ERR
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VALID, TX_BUSY,
        input  ALU_FUN, ALU_EN, CLK_GATE_EN, RF_WrEn, RF_Address, RF_WrData,
               TX_P_DATA, TX_D_VLD, ERR
    );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Command sequencer: parses UART command frames, loads RF operands, fires one
// ALU op with a timeout guard and streams the 16-bit result back low byte first.
module alu_cmd_ctrl #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 4,
    parameter int                    FUN_WIDTH   = 4,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP  = 8'hCC,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = 8'hDD,
    parameter int                    TIMEOUT     = 15
) (
    input  logic           CLK,
    input  logic           RST,
    alu_cmd_ctrl_if.master bus
);
    localparam int                CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [3:0] {
        IDLE, GET_A, GET_B, GET_FUN, RUN, SEND_LO, ACK_LO, SEND_HI, ACK_HI
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2*DATA_WIDTH-1:0] res_q, res_d;
    logic [FUN_WIDTH-1:0]    fun_q, fun_d;
    logic                    alu_en_q, alu_en_d;
    logic                    gate_q, gate_d;
    logic                    wren_q, wren_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   txd_q, txd_d;
    logic                    txv_q, txv_d;
    logic                    err_q, err_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        fun_d    = fun_q;
        alu_en_d = 1'b0;
        gate_d   = gate_q;
        wren_d   = 1'b0;
        addr_d   = '0;
        wdata_d  = '0;
        txd_d    = txd_q;
        txv_d    = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.RX_D_VLD) begin
                    if (bus.RX_P_DATA == CMD_ALU_OP)
                        state_d = GET_A;
                    else if (bus.RX_P_DATA == CMD_ALU_NOP)
                        state_d = GET_FUN;
                end
            end
            GET_A: begin
                if (bus.RX_D_VLD) begin
                    wren_d  = 1'b1;
                    addr_d  = ADDR_WIDTH'(0);
                    wdata_d = bus.RX_P_DATA;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (bus.RX_D_VLD) begin
                    wren_d  = 1'b1;
                    addr_d  = ADDR_WIDTH'(1);
                    wdata_d = bus.RX_P_DATA;
                    state_d = GET_FUN;
                end
            end
            GET_FUN: begin
                if (bus.RX_D_VLD) begin
                    fun_d    = bus.RX_P_DATA[FUN_WIDTH-1:0];
                    gate_d   = 1'b1;
                    alu_en_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            // A result on the final counted cycle still beats the timeout.
            RUN: begin
                if (bus.ALU_OUT_VALID) begin
                    res_d   = bus.ALU_OUT;
                    gate_d  = 1'b0;
                    state_d = SEND_LO;
                end else if (cnt_q == CNT_MAX) begin
                    err_d   = 1'b1;
                    gate_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SEND_LO: begin
                if (!bus.TX_BUSY) begin
                    txd_d   = res_q[DATA_WIDTH-1:0];
                    txv_d   = 1'b1;
                    state_d = ACK_LO;
                end
            end
            ACK_LO: begin
                if (bus.TX_BUSY) state_d = SEND_HI;
            end
            SEND_HI: begin
                if (!bus.TX_BUSY) begin
                    txd_d   = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
                    txv_d   = 1'b1;
                    state_d = ACK_HI;
                end
            end
            ACK_HI: begin
                if (bus.TX_BUSY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            res_q    <= '0;
            fun_q    <= '0;
            alu_en_q <= 1'b0;
            gate_q   <= 1'b0;
            wren_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            txd_q    <= '0;
            txv_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            fun_q    <= fun_d;
            alu_en_q <= alu_en_d;
            gate_q   <= gate_d;
            wren_q   <= wren_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            txd_q    <= txd_d;
            txv_q    <= txv_d;
            err_q    <= err_d;
        end
    end

    assign bus.ALU_FUN     = fun_q;
    assign bus.ALU_EN      = alu_en_q;
    assign bus.CLK_GATE_EN = gate_q;
    assign bus.RF_WrEn     = wren_q;
    assign bus.RF_Address  = addr_q;
    assign bus.RF_WrData   = wdata_q;
    assign bus.TX_P_DATA   = txd_q;
    assign bus.TX_D_VLD    = txv_q;
    assign bus.ERR         = err_q;
endmodule
